// File: rtl/trg_rate_mon_pkg.sv
// Shared definitions for the trigger-rate monitor: FSM encodings, widths and
// the saturating drop-counter increment.
package trg_rate_mon_pkg;

   localparam int CNT_W  = 32;
   localparam int DROP_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_ARM  = 3'b010,
      ST_RUN  = 3'b100
   } state_t;

   // Increment that sticks at all-ones instead of wrapping back to zero.
   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/trg_rate_fifo.sv
// Synchronous DEPTH x 32 rate FIFO with registered read data, a one-cycle
// read-valid pulse and registered occupancy flags.
module trg_rate_fifo
   import trg_rate_mon_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [CNT_W-1:0] din,
   output logic [CNT_W-1:0] dout,
   output logic             dout_vld,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      nsamples
);

   logic [CNT_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [CNT_W-1:0] dout_q, dout_d;
   logic             dout_vld_q, dout_vld_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             do_pop, do_push;

   // Pop needs data; a push into a full FIFO succeeds only if a pop frees a slot.
   always_comb begin
      do_pop     = pop & ~empty_q;
      do_push    = push & (~full_q | do_pop);
      wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
      empty_d    = (count_d == '0);
      full_d     = (count_d == (AW+1)'(DEPTH));
      dout_d     = do_pop ? mem_q[rd_ptr_q] : dout_q;
      dout_vld_d = do_pop;
   end

   // Control state and read register; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign empty    = empty_q;
   assign full     = full_q;
   assign nsamples = count_q;

endmodule

// File: rtl/trg_rate_mon.sv
// Trigger-rate monitor: samples the running trigger count every WINDOW clocks
// and queues the per-window increment for slow-control readout.
module trg_rate_mon
   import trg_rate_mon_pkg::*;
#(
   parameter int WINDOW = 100000,
   parameter int DEPTH  = 8,
   parameter int AW     = 3
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [CNT_W-1:0]  Ntriggers,
   input  logic              Enable,
   input  logic              RdReq,
   output logic [CNT_W-1:0]  Rate,
   output logic              RateValid,
   output logic              Empty,
   output logic              Full,
   output logic [AW:0]       NSamples,
   output logic [DROP_W-1:0] DropCnt
);

   localparam int             WCW      = $clog2(WINDOW);
   localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);

   state_t              state_q, state_d;
   logic [WCW-1:0]      win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0]    last_n_q, last_n_d;
   logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic                push;
   logic [CNT_W-1:0]    delta;
   logic                fifo_full;

   // State and window bookkeeping registers.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         win_cnt_q  <= '0;
         last_n_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         win_cnt_q  <= win_cnt_d;
         last_n_q   <= last_n_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Next-state: ARM lasts one cycle to capture the baseline count.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (Enable)  state_d = ST_ARM;
         ST_ARM:               state_d = ST_RUN;
         ST_RUN:  if (!Enable) state_d = ST_IDLE;
         default:              state_d = ST_IDLE;
      endcase
   end

   // Window counting, modulo-2^32 difference, FIFO push and drop accounting.
   always_comb begin
      push       = 1'b0;
      delta      = Ntriggers - last_n_q;
      win_cnt_d  = win_cnt_q;
      last_n_d   = last_n_q;
      drop_cnt_d = drop_cnt_q;
      case (state_q)
         ST_IDLE: win_cnt_d = '0;
         ST_ARM: begin
            last_n_d  = Ntriggers;
            win_cnt_d = '0;
         end
         ST_RUN: begin
            if (!Enable) begin
               win_cnt_d = '0;
            end else if (win_cnt_q == WIN_LAST) begin
               push      = 1'b1;
               last_n_d  = Ntriggers;
               win_cnt_d = '0;
            end else begin
               win_cnt_d = win_cnt_q + 1'b1;
            end
         end
         default: win_cnt_d = '0;
      endcase
      // A full FIFO is never empty, so RdReq alone means the pop frees a slot.
      if (push && fifo_full && !RdReq) begin
         drop_cnt_d = sat_inc(drop_cnt_q);
      end
   end

   trg_rate_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk      (Clock),
      .rst      (Reset),
      .push     (push),
      .pop      (RdReq),
      .din      (delta),
      .dout     (Rate),
      .dout_vld (RateValid),
      .empty    (Empty),
      .full     (fifo_full),
      .nsamples (NSamples)
   );

   assign Full    = fifo_full;
   assign DropCnt = drop_cnt_q;

endmodule

// File: tb/tb_trg_rate_mon.sv
// Self-checking bench for trg_rate_mon with WINDOW=16, DEPTH=4.
module tb_trg_rate_mon;

   localparam int WINDOW = 16;
   localparam int DEPTH  = 4;
   localparam int AW     = 2;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [31:0] Ntriggers;
   logic        Enable;
   logic        RdReq;
   logic [31:0] Rate;
   logic        RateValid;
   logic        Empty;
   logic        Full;
   logic [AW:0] NSamples;
   logic [7:0]  DropCnt;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];
   int          exp_drop = 0;

   always #5 Clock = ~Clock;

   trg_rate_mon #(
      .WINDOW (WINDOW),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Ntriggers (Ntriggers),
      .Enable    (Enable),
      .RdReq     (RdReq),
      .Rate      (Rate),
      .RateValid (RateValid),
      .Empty     (Empty),
      .Full      (Full),
      .NSamples  (NSamples),
      .DropCnt   (DropCnt)
   );

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // IDLE -> ARM edge, then ARM edge captures the baseline count.
   task automatic arm();
      Enable = 1'b1;
      tick();
      tick();
   endtask

   task automatic disable_mon();
      Enable = 1'b0;
      tick();
   endtask

   // One full window: Ntriggers += amt every per cycles; optional pop at cycle pop_at.
   task automatic run_window(input int per, input logic [31:0] amt, input logic [31:0] exp_delta,
                             input int pop_at, output logic obs_v, output logic [31:0] obs_r,
                             output logic exp_v, output logic [31:0] exp_r);
      exp_v = 1'b0;
      exp_r = '0;
      obs_v = 1'b0;
      obs_r = '0;
      for (int i = 0; i < WINDOW; i++) begin
         if (i % per == 0) Ntriggers = Ntriggers + amt;
         RdReq = (i == pop_at);
         if (i == pop_at && exp_q.size() > 0) begin
            exp_r = exp_q.pop_front();
            exp_v = 1'b1;
         end
         tick();
         if (i == pop_at) begin
            obs_v = RateValid;
            obs_r = Rate;
         end
      end
      RdReq = 1'b0;
      if (exp_q.size() < DEPTH) exp_q.push_back(exp_delta);
      else if (exp_drop < 255) exp_drop++;
   endtask

   task automatic pop_one(output logic v, output logic [31:0] r);
      RdReq = 1'b1;
      tick();
      v = RateValid;
      r = Rate;
      RdReq = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Enable = 1'b0; RdReq = 1'b0; Ntriggers = '0;
      tick();
      tick();
      Reset = 1'b0;
      checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", Empty); end
      checks++; if (Full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", Full); end
      checks++; if (NSamples !== 3'd0) begin errors++; $display("FAIL reset_nsamples: got %0d expected 0", NSamples); end
      checks++; if (Rate !== 32'd0 || RateValid !== 1'b0) begin errors++; $display("FAIL reset_rate: got %0d/%0b expected 0/0", Rate, RateValid); end
      checks++; if (DropCnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", DropCnt); end
   endtask

   task automatic test_basic();
      logic ov, ev; logic [31:0] orr, er;
      arm();
      run_window(4, 32'd1, 32'd4, -1, ov, orr, ev, er);
      checks++; if (NSamples !== 3'(exp_q.size())) begin errors++; $display("FAIL basic_nsamples: got %0d expected %0d", NSamples, exp_q.size()); end
      checks++; if (Empty !== 1'b0) begin errors++; $display("FAIL basic_empty: got %0b expected 0", Empty); end
      disable_mon();
      er = exp_q.pop_front();
      pop_one(ov, orr);
      checks++; if (ov !== 1'b1 || orr !== er) begin errors++; $display("FAIL basic_pop: got v=%0b rate=%0d expected v=1 rate=%0d", ov, orr, er); end
      tick();
      checks++; if (RateValid !== 1'b0 || Rate !== er) begin errors++; $display("FAIL basic_pulse: got v=%0b rate=%0d expected v=0 rate=%0d", RateValid, Rate, er); end
   endtask

   task automatic test_wrap();
      logic ov, ev; logic [31:0] orr, er;
      Ntriggers = 32'hFFFF_FFFE;
      arm();
      run_window(16, 32'd5, 32'd5, -1, ov, orr, ev, er);
      disable_mon();
      er = exp_q.pop_front();
      pop_one(ov, orr);
      checks++; if (ov !== 1'b1 || orr !== er) begin errors++; $display("FAIL wrap_pop: got v=%0b rate=%0d expected v=1 rate=%0d", ov, orr, er); end
   endtask

   task automatic test_overflow();
      logic ov, ev; logic [31:0] orr, er;
      arm();
      for (int w = 0; w < 6; w++) run_window(8, 32'd1, 32'd2, -1, ov, orr, ev, er);
      checks++; if (NSamples !== 3'd4 || NSamples !== 3'(exp_q.size())) begin errors++; $display("FAIL ovf_nsamples: got %0d expected 4", NSamples); end
      checks++; if (Full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %0b expected 1", Full); end
      checks++; if (DropCnt !== 8'(exp_drop) || DropCnt !== 8'd2) begin errors++; $display("FAIL ovf_drop: got %0d expected 2", DropCnt); end
   endtask

   task automatic test_full_coincident_pop();
      logic ov, ev; logic [31:0] orr, er;
      run_window(8, 32'd1, 32'd2, WINDOW - 1, ov, orr, ev, er);
      checks++; if (ov !== ev || orr !== er) begin errors++; $display("FAIL coinc_pop: got v=%0b rate=%0d expected v=%0b rate=%0d", ov, orr, ev, er); end
      checks++; if (DropCnt !== 8'(exp_drop)) begin errors++; $display("FAIL coinc_drop: got %0d expected %0d", DropCnt, exp_drop); end
      checks++; if (NSamples !== 3'd4) begin errors++; $display("FAIL coinc_nsamples: got %0d expected 4", NSamples); end
   endtask

   task automatic test_drop_saturate();
      logic ov, ev; logic [31:0] orr, er;
      for (int w = 0; w < 255; w++) run_window(8, 32'd1, 32'd2, -1, ov, orr, ev, er);
      checks++; if (DropCnt !== 8'd255 || exp_drop != 255) begin errors++; $display("FAIL drop_sat: got %0d expected 255", DropCnt); end
   endtask

   task automatic test_drain();
      logic ov; logic [31:0] orr, er;
      disable_mon();
      for (int k = 0; k < DEPTH; k++) begin
         er = exp_q.pop_front();
         pop_one(ov, orr);
         checks++; if (ov !== 1'b1 || orr !== er) begin errors++; $display("FAIL drain_pop%0d: got v=%0b rate=%0d expected v=1 rate=%0d", k, ov, orr, er); end
      end
      checks++; if (Empty !== 1'b1 || NSamples !== 3'd0) begin errors++; $display("FAIL drain_empty: got empty=%0b n=%0d expected 1/0", Empty, NSamples); end
      pop_one(ov, orr);
      checks++; if (ov !== 1'b0 || orr !== er) begin errors++; $display("FAIL empty_pop: got v=%0b rate=%0d expected v=0 rate=%0d", ov, orr, er); end
   endtask

   task automatic test_enable_toggle();
      logic ov, ev; logic [31:0] orr, er;
      arm();
      for (int i = 0; i < 8; i++) begin Ntriggers = Ntriggers + 1; tick(); end
      Enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) Ntriggers = Ntriggers + 1;
         tick();
      end
      checks++; if (NSamples !== 3'd0 || Empty !== 1'b1) begin errors++; $display("FAIL dis_nopush: got n=%0d expected 0", NSamples); end
      checks++; if (DropCnt !== 8'(exp_drop)) begin errors++; $display("FAIL dis_drop_kept: got %0d expected %0d", DropCnt, exp_drop); end
      arm();
      run_window(1, 32'd1, 32'd16, -1, ov, orr, ev, er);
      checks++; if (NSamples !== 3'd1) begin errors++; $display("FAIL rearm_nsamples: got %0d expected 1", NSamples); end
      disable_mon();
      er = exp_q.pop_front();
      pop_one(ov, orr);
      checks++; if (ov !== 1'b1 || orr !== er) begin errors++; $display("FAIL rearm_pop: got v=%0b rate=%0d expected v=1 rate=%0d", ov, orr, er); end
   endtask

   task automatic test_reset_midwindow();
      logic ov, ev; logic [31:0] orr, er;
      arm();
      for (int w = 0; w < 3; w++) run_window(4, 32'd3, 32'd12, -1, ov, orr, ev, er);
      for (int i = 0; i < 5; i++) begin Ntriggers = Ntriggers + 1; tick(); end
      checks++; if (NSamples !== 3'd3) begin errors++; $display("FAIL pre_reset_n: got %0d expected 3", NSamples); end
      Reset = 1'b1; RdReq = 1'b1;
      tick();
      exp_q.delete();
      exp_drop = 0;
      checks++; if (Empty !== 1'b1 || NSamples !== 3'd0) begin errors++; $display("FAIL mid_reset_fifo: got empty=%0b n=%0d expected 1/0", Empty, NSamples); end
      checks++; if (DropCnt !== 8'd0 || Rate !== 32'd0 || RateValid !== 1'b0) begin errors++; $display("FAIL mid_reset_out: got drop=%0d rate=%0d v=%0b expected 0/0/0", DropCnt, Rate, RateValid); end
      checks++; if (dut.state_q !== 3'b001) begin errors++; $display("FAIL mid_reset_state: got %b expected 001", dut.state_q); end
      Reset = 1'b0; RdReq = 1'b0; Enable = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_overflow();
      test_full_coincident_pop();
      test_drop_saturate();
      test_drain();
      test_enable_toggle();
      test_reset_midwindow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
